// File: rtl/rv32i_types.sv
// Shared type package for the memory-side blocks.
//   arb_mode_e  : arbitration policy for mem_arbiter_rr
//   arb_state_e : mem_arbiter_rr controller states
package rv32i_types;

   typedef enum logic {
      ARB_RR,
      ARB_FIXED
   } arb_mode_e;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Rotating-base priority encoder. Returns the first set bit of i_req at or
// after i_base, wrapping modulo NUM_PORTS. A base of 0 gives plain
// lowest-index-wins priority.
//   i_req   : request vector, one bit per port
//   i_base  : index searched first (must be < NUM_PORTS)
//   o_valid : at least one request present
//   o_idx   : index of the chosen request (0 when none)
module rr_picker #(
   parameter int  NUM_PORTS = 2,
   localparam int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [IDX_W-1:0]     i_base,
   output logic                 o_valid,
   output logic [IDX_W-1:0]     o_idx
);

   // Walk from the farthest offset down to offset 0 so the nearest
   // requester to the base is the last (winning) assignment.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (i_req[(int'(i_base) + k) % NUM_PORTS]) begin
            o_valid = 1'b1;
            o_idx   = IDX_W'((int'(i_base) + k) % NUM_PORTS);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port arbiter in front of a single physical memory port.
// The winning request (port, op, address, write line) is latched on grant, so
// the memory side sees only the latched copy until completion. On completion
// the next winner is chosen in the same cycle, giving back-to-back grants.
//
//   state    | meaning
//   ARB_IDLE | no transaction outstanding, pmem outputs held at 0
//   ARB_BUSY | latched request driven to pmem, waiting for pmem_resp
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_read/req_write       : per-port requests, held until that port's resp
//   req_address/req_wdata    : per-port address / write line, port i at slice i
//   req_rdata, req_resp      : shared read line, one-hot completion pulse
//   pmem_*                   : physical memory port
//   busy, grant_id           : transaction outstanding, granted port (0 idle)
module mem_arbiter_rr
   import rv32i_types::*;
#(
   parameter int        NUM_PORTS = 2,
   parameter int        LINE_W    = 256,
   parameter int        ADDR_W    = 32,
   parameter arb_mode_e ARB_MODE  = ARB_RR,
   localparam int       IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        req_read,
   input  logic [NUM_PORTS-1:0]        req_write,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
   input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
   output logic [LINE_W-1:0]           req_rdata,
   output logic [NUM_PORTS-1:0]        req_resp,
   output logic                        pmem_read,
   output logic                        pmem_write,
   output logic [ADDR_W-1:0]           pmem_address,
   output logic [LINE_W-1:0]           pmem_wdata,
   input  logic [LINE_W-1:0]           pmem_rdata,
   input  logic                        pmem_resp,
   output logic                        busy,
   output logic [IDX_W-1:0]            grant_id
);

   arb_state_e           r_state, w_state_nxt;
   logic [IDX_W-1:0]     r_rr_ptr;
   logic [IDX_W-1:0]     r_grant;
   logic                 r_op_write;
   logic [ADDR_W-1:0]    r_addr;
   logic [LINE_W-1:0]    r_wdata;

   logic [NUM_PORTS-1:0] w_req;
   logic [NUM_PORTS-1:0] w_grant_oh;
   logic [NUM_PORTS-1:0] w_cand;
   logic [IDX_W-1:0]     w_base;
   logic [IDX_W-1:0]     w_pick_idx;
   logic [IDX_W-1:0]     w_rr_nxt;
   logic                 w_pick_valid;
   logic                 w_load;

   assign w_req      = req_read | req_write;
   assign w_grant_oh = NUM_PORTS'(1) << r_grant;

   // The port being completed still holds its request during its resp cycle;
   // mask it so it cannot win again off a request it is about to drop.
   assign w_cand = (r_state == ARB_BUSY) ? (w_req & ~w_grant_oh) : w_req;
   assign w_base = (ARB_MODE == ARB_FIXED) ? '0 : r_rr_ptr;

   rr_picker #(
      .NUM_PORTS (NUM_PORTS)
   ) u_picker (
      .i_req   (w_cand),
      .i_base  (w_base),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   assign w_rr_nxt = (w_pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_pick_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ARB_IDLE;
         r_rr_ptr   <= '0;
         r_grant    <= '0;
         r_op_write <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_grant    <= w_pick_idx;
            // A simultaneous read+write is issued as a write.
            r_op_write <= req_write[w_pick_idx];
            r_addr     <= req_address[int'(w_pick_idx) * ADDR_W +: ADDR_W];
            r_wdata    <= req_wdata[int'(w_pick_idx) * LINE_W +: LINE_W];
            if (ARB_MODE == ARB_RR) begin
               r_rr_ptr <= w_rr_nxt;
            end
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_load       = 1'b0;
      req_resp     = '0;
      req_rdata    = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      busy         = 1'b0;
      grant_id     = '0;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_valid) begin
               w_load      = 1'b1;
               w_state_nxt = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            busy         = 1'b1;
            grant_id     = r_grant;
            pmem_read    = ~r_op_write;
            pmem_write   = r_op_write;
            pmem_address = r_addr;
            pmem_wdata   = r_wdata;
            if (pmem_resp) begin
               req_resp  = w_grant_oh;
               req_rdata = pmem_rdata;
               if (w_pick_valid) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = ARB_IDLE;
               end
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            assert (!(req_read[i] && req_write[i]))
               else $warning("port %0d requests read and write together; write issued, read dropped", i);
         end
         assert ($onehot0(req_resp))
            else $error("req_resp multi-hot: %b", req_resp);
      end
   end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;
   import rv32i_types::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // dut_a: 2 ports, round robin, default widths
   logic [1:0]   a_req_read = '0, a_req_write = '0;
   logic [63:0]  a_req_address = '0;
   logic [511:0] a_req_wdata = '0;
   logic [255:0] a_req_rdata, a_pmem_wdata;
   logic [255:0] a_pmem_rdata = '0;
   logic [1:0]   a_req_resp;
   logic         a_pmem_read, a_pmem_write, a_busy;
   logic         a_pmem_resp = 1'b0;
   logic [31:0]  a_pmem_address;
   logic         a_grant_id;

   mem_arbiter_rr #(.NUM_PORTS(2), .LINE_W(256), .ADDR_W(32), .ARB_MODE(ARB_RR)) dut_a (
      .clk(clk), .rst(rst),
      .req_read(a_req_read), .req_write(a_req_write),
      .req_address(a_req_address), .req_wdata(a_req_wdata),
      .req_rdata(a_req_rdata), .req_resp(a_req_resp),
      .pmem_read(a_pmem_read), .pmem_write(a_pmem_write),
      .pmem_address(a_pmem_address), .pmem_wdata(a_pmem_wdata),
      .pmem_rdata(a_pmem_rdata), .pmem_resp(a_pmem_resp),
      .busy(a_busy), .grant_id(a_grant_id)
   );

   // dut_b: 3 ports round robin; dut_c: 3 ports fixed priority
   logic [2:0]  b_req_read = '0, c_req_read = '0;
   logic [2:0]  b_req_write = '0, c_req_write = '0;
   logic [47:0] b_req_address = {16'h0300, 16'h0200, 16'h0100};
   logic [47:0] c_req_address = {16'h0300, 16'h0200, 16'h0100};
   logic [95:0] b_req_wdata = '0, c_req_wdata = '0;
   logic [31:0] b_req_rdata, c_req_rdata, b_pmem_wdata, c_pmem_wdata;
   logic [31:0] b_pmem_rdata = 32'h1234_5678, c_pmem_rdata = 32'h8765_4321;
   logic [2:0]  b_req_resp, c_req_resp;
   logic        b_pmem_read, b_pmem_write, b_busy, c_pmem_read, c_pmem_write, c_busy;
   logic        b_pmem_resp = 1'b0, c_pmem_resp = 1'b0;
   logic [15:0] b_pmem_address, c_pmem_address;
   logic [1:0]  b_grant_id, c_grant_id;

   mem_arbiter_rr #(.NUM_PORTS(3), .LINE_W(32), .ADDR_W(16), .ARB_MODE(ARB_RR)) dut_b (
      .clk(clk), .rst(rst),
      .req_read(b_req_read), .req_write(b_req_write),
      .req_address(b_req_address), .req_wdata(b_req_wdata),
      .req_rdata(b_req_rdata), .req_resp(b_req_resp),
      .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
      .pmem_address(b_pmem_address), .pmem_wdata(b_pmem_wdata),
      .pmem_rdata(b_pmem_rdata), .pmem_resp(b_pmem_resp),
      .busy(b_busy), .grant_id(b_grant_id)
   );

   mem_arbiter_rr #(.NUM_PORTS(3), .LINE_W(32), .ADDR_W(16), .ARB_MODE(ARB_FIXED)) dut_c (
      .clk(clk), .rst(rst),
      .req_read(c_req_read), .req_write(c_req_write),
      .req_address(c_req_address), .req_wdata(c_req_wdata),
      .req_rdata(c_req_rdata), .req_resp(c_req_resp),
      .pmem_read(c_pmem_read), .pmem_write(c_pmem_write),
      .pmem_address(c_pmem_address), .pmem_wdata(c_pmem_wdata),
      .pmem_rdata(c_pmem_rdata), .pmem_resp(c_pmem_resp),
      .busy(c_busy), .grant_id(c_grant_id)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp)
         else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   localparam logic [255:0] RDATA_A = {8{32'hDEAD_BEEF}};
   localparam logic [255:0] LINE_AA = {32{8'hAA}};
   localparam logic [255:0] LINE_55 = {32{8'h55}};

   int          exp_rr[6] = '{0, 1, 2, 0, 1, 2};
   int          exp_fx[6] = '{0, 1, 0, 2, 0, 1};
   logic [2:0]  req_fx[6] = '{3'b111, 3'b101, 3'b111, 3'b011, 3'b011, 3'b001};
   logic [2:0]  oh;

   initial begin
      // ---------------- reset state
      step();
      step();
      rst = 1'b0;
      chk("rst_busy_a",  a_busy, 0);
      chk("rst_grant_a", a_grant_id, 0);
      chk("rst_rd_a",    a_pmem_read, 0);
      chk("rst_wr_a",    a_pmem_write, 0);
      chk("rst_addr_a",  a_pmem_address, 0);
      chk("rst_resp_a",  a_req_resp, 0);
      chk("rst_busy_b",  b_busy, 0);
      chk("rst_busy_c",  c_busy, 0);

      // ---------------- 1: port1 read @0x1000, resp in 3rd busy cycle
      a_req_read    = 2'b10;
      a_req_address = {32'h0000_1000, 32'h0};
      a_pmem_rdata  = RDATA_A;
      #1;
      chk("t1_rd_c0", a_pmem_read, 0);
      step();
      chk("t1_rd_c1",    a_pmem_read, 1);
      chk("t1_wr_c1",    a_pmem_write, 0);
      chk("t1_addr_c1",  a_pmem_address, 32'h1000);
      chk("t1_busy_c1",  a_busy, 1);
      chk("t1_grant_c1", a_grant_id, 1);
      chk("t1_noresp",   a_req_resp, 0);
      chk("t1_rdata0",   a_req_rdata, 0);
      step();
      step();
      a_pmem_resp = 1'b1;
      #1;
      chk("t1_resp",  a_req_resp, 2'b10);
      chk("t1_rdata", a_req_rdata, RDATA_A);
      step();
      a_pmem_resp = 1'b0;
      a_req_read  = 2'b00;
      #1;
      chk("t1_idle_busy", a_busy, 0);
      chk("t1_idle_rd",   a_pmem_read, 0);

      // ---------------- 4: port0 write @0x40, requester perturbs while busy
      a_req_write          = 2'b01;
      a_req_address[31:0]  = 32'h40;
      a_req_wdata[255:0]   = LINE_AA;
      step();
      chk("t4_wr",    a_pmem_write, 1);
      chk("t4_rd",    a_pmem_read, 0);
      chk("t4_grant", a_grant_id, 0);
      chk("t4_addr",  a_pmem_address, 32'h40);
      chk("t4_wdata", a_pmem_wdata, LINE_AA);
      a_req_address[31:0] = 32'h80;
      a_req_wdata[255:0]  = LINE_55;
      step();
      chk("t4_addr_held",  a_pmem_address, 32'h40);
      chk("t4_wdata_held", a_pmem_wdata, LINE_AA);
      a_pmem_resp = 1'b1;
      #1;
      chk("t4_resp",      a_req_resp, 2'b01);
      chk("t4_addr_resp", a_pmem_address, 32'h40);
      step();
      a_pmem_resp = 1'b0;
      a_req_write = 2'b00;
      #1;
      chk("t4_idle", a_busy, 0);

      // ---------------- 5: reset while busy on port1, port0 pending
      a_req_read    = 2'b10;
      a_req_address = {32'h0000_2000, 32'h0000_3000};
      step();
      chk("t5_grant1", a_grant_id, 1);
      a_req_read = 2'b11;
      step();
      chk("t5_busy", a_busy, 1);
      rst = 1'b1;
      step();
      chk("t5_rst_busy",  a_busy, 0);
      chk("t5_rst_grant", a_grant_id, 0);
      chk("t5_rst_rd",    a_pmem_read, 0);
      chk("t5_rst_addr",  a_pmem_address, 0);
      chk("t5_rst_resp",  a_req_resp, 0);
      step();
      chk("t5_rst_hold", a_busy, 0);
      rst = 1'b0;
      step();
      chk("t5_post_grant", a_grant_id, 0);
      chk("t5_post_addr",  a_pmem_address, 32'h3000);
      a_pmem_resp = 1'b1;
      #1;
      chk("t5_resp0", a_req_resp, 2'b01);
      step();
      a_req_read = 2'b10;
      #1;
      chk("t5_b2b_busy",  a_busy, 1);
      chk("t5_b2b_grant", a_grant_id, 1);
      chk("t5_b2b_addr",  a_pmem_address, 32'h2000);
      chk("t5_resp1", a_req_resp, 2'b10);
      step();
      a_pmem_resp = 1'b0;
      a_req_read  = 2'b00;
      #1;
      chk("t5_idle", a_busy, 0);

      // ---------------- 6: stray resp in idle, dual read+write request
      a_pmem_resp = 1'b1;
      #1;
      chk("t6_stray_resp",  a_req_resp, 0);
      chk("t6_stray_rdata", a_req_rdata, 0);
      step();
      chk("t6_stray_busy", a_busy, 0);
      a_pmem_resp         = 1'b0;
      a_req_read          = 2'b01;
      a_req_write         = 2'b01;
      a_req_address[31:0] = 32'h500;
      step();
      chk("t6_dual_wr",   a_pmem_write, 1);
      chk("t6_dual_rd",   a_pmem_read, 0);
      chk("t6_dual_addr", a_pmem_address, 32'h500);
      a_pmem_resp = 1'b1;
      #1;
      chk("t6_dual_resp", a_req_resp, 2'b01);
      step();
      a_pmem_resp = 1'b0;
      a_req_read  = 2'b00;
      a_req_write = 2'b00;
      #1;
      chk("t6_idle", a_busy, 0);

      // ---------------- 2: 3-port round robin, all requesting continuously
      b_req_read = 3'b111;
      step();
      for (int t = 0; t < 6; t++) begin
         chk($sformatf("t2_grant%0d", t), b_grant_id, exp_rr[t]);
         chk($sformatf("t2_busy%0d", t),  b_busy, 1);
         chk($sformatf("t2_addr%0d", t),  b_pmem_address, (exp_rr[t] + 1) * 256);
         step();
         b_pmem_resp = 1'b1;
         #1;
         oh = 3'b001 << exp_rr[t];
         chk($sformatf("t2_resp%0d", t),  b_req_resp, oh);
         chk($sformatf("t2_rdata%0d", t), b_req_rdata, 32'h1234_5678);
         step();
         b_pmem_resp = 1'b0;
      end
      b_req_read  = 3'b001;
      b_pmem_resp = 1'b1;
      step();
      b_pmem_resp = 1'b0;
      b_req_read  = 3'b000;
      #1;
      chk("t2_idle", b_busy, 0);

      // ---------------- 3: 3-port fixed priority, port0 re-requests at once
      c_req_read = 3'b111;
      step();
      for (int t = 0; t < 6; t++) begin
         chk($sformatf("t3_grant%0d", t), c_grant_id, exp_fx[t]);
         chk($sformatf("t3_busy%0d", t),  c_busy, 1);
         step();
         c_pmem_resp = 1'b1;
         #1;
         oh = 3'b001 << exp_fx[t];
         chk($sformatf("t3_resp%0d", t), c_req_resp, oh);
         step();
         c_pmem_resp = 1'b0;
         c_req_read  = req_fx[t];
      end
      c_pmem_resp = 1'b1;
      step();
      c_pmem_resp = 1'b0;
      c_req_read  = 3'b000;
      #1;
      chk("t3_idle", c_busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
N-port arbiter between cache-side memory requesters (I-cache, D-cache, prefetcher, ...) and one physical memory / cacheline adaptor port.
- Supersedes the fixed 2-port instruction/data arbiter.
- Parametrised port count, line width and address width.
- Selectable round-robin or fixed-priority arbitration.
- Latches the granted request so the requester cannot perturb pmem mid-transaction.
- Back-to-back grants without an idle bubble.

Parameters:
NUM_PORTS, 2, number of requesters (>=2); index 0 is highest fixed priority.
LINE_W, 256, cacheline data width in bits.
ADDR_W, 32, address width.
ARB_MODE, ARB_RR, arb_mode_e: ARB_RR = round robin, ARB_FIXED = lowest index wins.
IDX_W, $clog2(NUM_PORTS), derived, not overridable.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_read  in  NUM_PORTS  per-port read request, held until that port's resp
req_write  in  NUM_PORTS  per-port write request, held until that port's resp
req_address  in  NUM_PORTS x ADDR_W  per-port address
req_wdata  in  NUM_PORTS x LINE_W  per-port write line
req_rdata  out  LINE_W  shared read line, valid only with a resp bit
req_resp  out  NUM_PORTS  one-hot completion pulse
pmem_read  out  1  memory read
pmem_write  out  1  memory write
pmem_address  out  ADDR_W  memory address
pmem_wdata  out  LINE_W  memory write line
pmem_rdata  in  LINE_W  memory read line
pmem_resp  in  1  memory completion
busy  out  1  transaction outstanding
grant_id  out  IDX_W  granted port index; 0 when idle

Behaviour:
- States: IDLE, BUSY.
- Reset (rst high at posedge):
  - state=IDLE, rr_ptr=0, all latches cleared.
  - All outputs 0 the next cycle.
  - rst mid-BUSY abandons the transaction; pmem is reset in the same cycle by system convention.
- A port requests when req_read[i] | req_write[i]. If both are set, the write is issued and the read is ignored; this is flagged by an assertion.
- Winner selection (combinational):
  - ARB_FIXED: lowest requesting index.
  - ARB_RR: first requesting index at or after rr_ptr, wrapping modulo NUM_PORTS.
- IDLE:
  - No request: stay IDLE; all pmem outputs 0.
  - Any request: latch winner index, op (rd/wr), address and wdata at the posedge; go to BUSY. Grant latency is 1 cycle from request.
  - ARB_RR: rr_ptr <= winner+1, wrapping NUM_PORTS-1 -> 0.
- BUSY:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are driven only from the latches. Requester input changes are ignored.
  - busy=1; grant_id = latched index.
- Completion (pmem_resp=1 in BUSY):
  - Same cycle: req_resp[grant]=1 and req_rdata=pmem_rdata (pass-through). req_rdata is 0 when no resp bit is set.
  - Same cycle: re-arbitrate with the current grant's bit masked, because that requester still holds req this cycle.
  - Winner exists: latch it and stay BUSY. pmem_read/pmem_write deassert for exactly 0 cycles; the new op appears the next cycle.
  - No winner: go to IDLE.
- Starvation bound (ARB_RR): with all ports continuously requesting, each port is granted at least once every NUM_PORTS transactions.
- pmem_resp in IDLE is ignored; no resp is routed.
- req_resp is never multi-hot and never asserted in IDLE.

Decomposition:
- Shared package rv32i_types gains:
  - arb_mode_e {ARB_RR, ARB_FIXED}.
  - arb_state_e {ARB_IDLE, ARB_BUSY}.
- Sub-module rr_picker:
  - Combinational rotating-base priority encoder.
  - Inputs: NUM_PORTS req vector, base index.
  - Outputs: valid, IDX_W index.
  - Fixed mode drives base=0.
  - Unit-testable standalone.

Test Plan:
1. Reset, then port1 read @0x0000_1000, pmem_resp after 3 cycles.
   -> pmem_read=1 with addr 0x1000 from cycle 1; req_resp=2'b10 the same cycle as pmem_resp; req_rdata=pmem_rdata; busy drops the next cycle.
2. NUM_PORTS=3, ARB_RR, all ports requesting continuously, pmem_resp every 2 cycles.
   -> grant_id sequence 0,1,2,0,1,2; no IDLE cycle between transactions.
3. Same stimulus as 2 with ARB_FIXED, port0 re-requests immediately after each resp.
   -> grant alternates 0,1,0,2,0,1 (port masked only on its own resp cycle); ports 1/2 are never granted twice in a row.
4. Port0 write @0x40 wdata=0xAA..; requester changes address to 0x80 while BUSY.
   -> pmem_address stays 0x40 and pmem_wdata stays the latched line until resp.
5. rst asserted while BUSY on port1.
   -> next cycle: all outputs 0, state IDLE, rr_ptr=0; a pending port0 request is granted first after reset.
6. Stray pmem_resp=1 while IDLE, and port driving req_read=req_write=1.
   -> no req_resp bit set; the dual request issues pmem_write only and fires the assertion.
